// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Hex glyphs 0..F; lower-case b and d keep them distinct from 8 and 0.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Scan position; digit 0 is the rightmost digit.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output seg_t       o_seg
);

  // Straight table lookup; every nibble value has a glyph.
  always_comb begin
    o_seg = SEG_TABLE[i_hex];
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A new value is taken only at the frame boundary so a frame never mixes
// two values, and each digit slot opens with an all-anodes-off guard to
// keep the previous digit's segments from ghosting onto the next anode.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading
// zeros on digits 3..1 (digit 0 is always lit).
//
// state | meaning
// DIG0  | scanning digit 0 (rightmost), value_in[3:0]
// DIG1  | scanning digit 1, value_in[7:4]
// DIG2  | scanning digit 2, value_in[11:8]
// DIG3  | scanning digit 3; last slot cycle is the frame boundary
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,  // cycles per digit slot, >= 4
  parameter int GUARD       = 16       // 1 <= GUARD < REFRESH_DIV
) (
  input  logic        clock_100MHz,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        blank,
  output logic [3:0]  Anodes,
  output logic [6:0]  Cathodes,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  logic [CNT_W-1:0] r_cnt;
  dig_e             r_dig;
  logic [15:0]      r_disp;
  logic [3:0]       r_anodes;
  seg_t             r_cathodes;
  logic             r_frame_tick;

  logic             w_slot_end;
  logic             w_frame_end;
  logic [3:0]       w_nibble;
  seg_t             w_seg;
  logic             w_lz_blank;
  logic             w_dark;
  logic [3:0]       w_anode_sel;

  // Slot and frame boundaries; value_ready is the frame boundary itself.
  always_comb begin
    w_slot_end  = (r_cnt == CNT_LAST);
    w_frame_end = w_slot_end && (r_dig == DIG3);
  end

  assign value_ready = w_frame_end;

  // Select the nibble and anode for the digit currently being scanned.
  always_comb begin
    w_nibble = r_disp[3:0];
    case (r_dig)
      DIG0:    w_nibble = r_disp[3:0];
      DIG1:    w_nibble = r_disp[7:4];
      DIG2:    w_nibble = r_disp[11:8];
      DIG3:    w_nibble = r_disp[15:12];
      default: w_nibble = r_disp[3:0];
    endcase
    w_anode_sel = ~(4'b0001 << r_dig);
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // A digit is dark when it and every digit to its left are zero.
  always_comb begin
    w_lz_blank = 1'b0;
    case (r_dig)
      DIG3:    w_lz_blank = (r_disp[15:12] == 4'h0);
      DIG2:    w_lz_blank = (r_disp[15:8] == 8'h00);
      DIG1:    w_lz_blank = (r_disp[15:4] == 12'h000);
      default: w_lz_blank = 1'b0;
    endcase
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  // Guard window, external blank and leading-zero suppression all turn the anodes off.
  always_comb begin
    w_dark = (r_cnt < CNT_GUARD) || blank || w_lz_blank;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_hex (w_nibble),
    .o_seg (w_seg)
  );

  // Scan FSM: prescaler, digit sequencing, frame capture and registered outputs.
  always_ff @(posedge clock_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_dig        <= DIG0;
      r_disp       <= 16'h0000;
      r_anodes     <= 4'b1111;
      r_cathodes   <= SEG_BLANK;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        case (r_dig)
          DIG0:    r_dig <= DIG1;
          DIG1:    r_dig <= DIG2;
          DIG2:    r_dig <= DIG3;
          DIG3:    r_dig <= DIG0;
          default: r_dig <= DIG0;
        endcase
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_frame_end && value_valid) begin
        r_disp <= value_in;
      end

      // Cathodes are left untouched while dark so nothing toggles under an off anode.
      if (w_dark) begin
        r_anodes <= 4'b1111;
      end else begin
        r_anodes   <= w_anode_sel;
        r_cathodes <= w_seg;
      end

      r_frame_tick <= w_frame_end;
    end
  end

  assign Anodes     = r_anodes;
  assign Cathodes   = r_cathodes;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV=8, GUARD=2.
// Observation point n is the falling edge after the n-th rising edge since
// reset release; outputs seen there reflect scan cycle n-1.
module tb_seven_seg_scan;

  localparam int RDIV = 8;
  localparam int GRD  = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic        value_valid;
  logic        value_ready;
  logic        blank;
  logic [3:0]  anodes;
  logic [6:0]  cathodes;
  logic        frame_tick;

  int n_checks;
  int n_err;

  logic [6:0] seg_ref [16];
  logic [6:0] last_cath;

  seven_seg_scan #(
    .REFRESH_DIV (RDIV),
    .GUARD       (GRD)
  ) dut (
    .clock_100MHz (clk),
    .reset_n      (rst_n),
    .value_in     (value_in),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .blank        (blank),
    .Anodes       (anodes),
    .Cathodes     (cathodes),
    .frame_tick   (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit lz_dark(input int d, input logic [15:0] v);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [15:0] hi;
    hi = v >> (4 * d);
    return (d > 0) && (hi == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_an"},    32'(anodes),      32'hF);
    chk({tag, "_cath"},  32'(cathodes),    32'h7F);
    chk({tag, "_tick"},  32'(frame_tick),  32'h0);
    chk({tag, "_ready"}, 32'(value_ready), 32'h0);
    last_cath = 7'h7F;
  endtask

  task automatic check_cycle(input int n, input logic [15:0] v, input bit blanked);
    int c, d;
    bit lit;
    logic [3:0] nib;
    logic [3:0] exp_an;
    logic [15:0] sh;
    c = (n - 1) % RDIV;
    d = ((n - 1) / RDIV) % 4;
    lit = (c >= GRD) && !blanked && !lz_dark(d, v);
    if (lit) begin
      sh = v >> (4 * d);
      nib = sh[3:0];
      exp_an = ~(4'b0001 << d);
      last_cath = seg_ref[nib];
    end else begin
      exp_an = 4'b1111;
    end
    chk($sformatf("an_n%0d", n),    32'(anodes),      32'(exp_an));
    chk($sformatf("cath_n%0d", n),  32'(cathodes),    32'(last_cath));
    chk($sformatf("ready_n%0d", n), 32'(value_ready), 32'((n % 32) == 31));
    chk($sformatf("tick_n%0d", n),  32'(frame_tick),  32'((n % 32) == 0));
  endtask

  function automatic logic [15:0] shown_main(input int n);
    int f;
    f = (n - 1) / 32;
    if (f <= 1) return 16'h0000;
    if (f <= 4) return 16'h12AF;
    return 16'h00A0;
  endfunction

  initial begin
    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    n_checks    = 0;
    n_err       = 0;
    last_cath   = 7'h7F;
    rst_n       = 1'b0;
    value_in    = 16'h0000;
    value_valid = 1'b0;
    blank       = 1'b0;

    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset($sformatf("rst%0d", i));
    end
    rst_n = 1'b1;

    // Main directed run: 0000 frames, 12AF capture, ignored pulse, blank, 00A0.
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(n, shown_main(n), (n >= 132) && (n <= 134));
      case (n)
        40:  begin value_valid = 1'b1; value_in = 16'h12AF; end
        70:  value_valid = 1'b0;
        100: begin value_valid = 1'b1; value_in = 16'h8888; end
        101: begin value_valid = 1'b0; value_in = 16'h12AF; end
        131: blank = 1'b1;
        134: blank = 1'b0;
        150: begin value_valid = 1'b1; value_in = 16'h00A0; end
        170: value_valid = 1'b0;
        default: ;
      endcase
    end

    // Mid-frame reset takes effect immediately.
    rst_n = 1'b0;
    #1;
    check_reset("midrst_now");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset($sformatf("midrst%0d", i));
    end
    rst_n = 1'b1;

    // After release the display restarts at digit 0 showing 0000.
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(n, 16'h0000, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
